lutram_fifo: RTL and testbench
==============================

LUTRAM_FIFO -- requirements
Module: lutram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, RAM word count; power of 2, >= 2.
REQ-003 SHALL have parameter AF_TH, default DEPTH-2, almost-full threshold in words.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port s_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  input  WIDTH  write data.
REQ-007 SHALL have port in_vld  input  1  write request.
REQ-008 SHALL have port in_rdy  output  1  space available.
REQ-009 SHALL have port out_data  output  WIDTH  head-of-queue data.
REQ-010 SHALL have port out_vld  output  1  head data valid.
REQ-011 SHALL have port out_rdy  input  1  consumer accepts.
REQ-012 SHALL have port occ  output  OCC_W  words held; OCC_W = $clog2(CAP+1), where CAP is total capacity.
REQ-013 SHALL have port almost_full  output  1  occ >= AF_TH.

Function
REQ-014 SHALL push when in_vld && in_rdy and pop when out_vld && out_rdy; data SHALL leave in push order.
REQ-015 SHALL keep wr_ptr and rd_ptr ADD_W+1 bits wide; the MSB is a wrap bit.
- empty: pointers equal.
- full: low bits equal, MSB differs.
- pointers SHALL wrap modulo 2*DEPTH with no special case.
REQ-016 SHALL drive in_rdy = !ram_full combinationally from registers; no dependency on out_rdy.
- A push is refused when the RAM is full, even on a simultaneous pop (no bypass).
REQ-017 SHALL accept a simultaneous push and pop at any non-full, non-empty RAM level, with occ unchanged.
REQ-018 SHALL update occ every cycle by +1 on push, -1 on pop, 0 on both or neither; no wrap below 0 or above CAP.
REQ-019 SHALL register almost_full, matching the occ value of the same cycle.
REQ-020 SHALL ignore out_rdy while out_vld=0 and ignore in_data while in_vld=0.
REQ-021 SHALL leave out_data undefined while out_vld=0; the bench SHALL NOT check it.

Reset
REQ-022 SHALL hold on s_rst_n=0:
- wr_ptr=0, rd_ptr=0, occ=0
- out_vld=0, in_rdy=0, almost_full=0
- output stage in OUT_EMPTY
REQ-023 SHALL raise in_rdy=1 in the first cycle after reset release.
REQ-024 SHALL NOT reset RAM contents; reset mid-operation discards all stored words.

Configuration
REQ-025 SHALL implement macro LUTRAM_FIFO_OUT_REG_EN to control the output stage.
REQ-026 Without the macro:
- out_data SHALL be the combinational RAM read at rd_ptr.
- out_vld SHALL equal !empty.
- CAP = DEPTH.
- push to out_vld latency into an empty FIFO SHALL be 1 cycle.
REQ-027 With the macro, SHALL add a registered output stage with FSM states OUT_EMPTY and OUT_FULL.
- OUT_EMPTY -> OUT_FULL when the RAM is non-empty; the stage loads from the RAM and increments rd_ptr.
- OUT_FULL -> OUT_FULL on pop with the RAM non-empty; the stage reloads in the same cycle.
- OUT_FULL -> OUT_EMPTY on pop with the RAM empty.
- out_vld SHALL be 1 exactly in OUT_FULL; out_data SHALL come from a flop.
- CAP = DEPTH+1; latency into an empty FIFO SHALL be 2 cycles.
- Full-rate streaming SHALL be 1 word per cycle with no bubbles.

Structure
REQ-028 SHALL define out_st_e {OUT_EMPTY, OUT_FULL} in the shared package ram_wrapper_pkg.
- Width-dependent types remain localparams, because they derive from module parameters.
REQ-029 SHALL instantiate ram_NR1W_behav_core for storage, with RD_PORT_NB=1 and HAS_RST=0.
- wr_add = wr_ptr[ADD_W-1:0]
- rd_add[0] = rd_ptr[ADD_W-1:0]

Verification
REQ-030 Reset/first word: DEPTH=16, release reset, push 0xA5 in cycle 0 -> out_vld=1, out_data=0xA5 at cycle 1 (cycle 2 with the macro); occ=1.
REQ-031 Fill: push 16 words, out_rdy=0 -> in_rdy=0 after the 16th push without the macro (17th with the macro); occ=CAP; almost_full=1 from occ=14; extra in_vld is ignored and data is unchanged.
REQ-032 Full plus simultaneous pop: full FIFO, in_vld=1, out_rdy=1 -> pop only, occ=CAP-1, in_rdy=1 next cycle.
REQ-033 Wrap: stream 40 incrementing words at in_vld=out_rdy=1 -> output 0..39 in order, no gaps after the first, occ steady at 1 (2 with the macro).
REQ-034 Random backpressure: 1000 words, 50% random in_vld and out_rdy -> scoreboard match, occ equals the model count every cycle.
REQ-035 Reset mid-operation: occ=7, assert s_rst_n=0 for 1 cycle -> occ=0, out_vld=0 next cycle, in_rdy=1 after release, old words never appear.

Source files
------------

// File: rtl/ram_wrapper_pkg.sv
// Shared types for the RAM-wrapper family of blocks (output stage FSM states).
// Width-dependent types stay as localparams inside each module, since they derive from module parameters.
package ram_wrapper_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_st_e;

endpackage

// File: rtl/ram_NR1W_behav_core.sv
// Behavioural N-read / 1-write register-file RAM.
// Reads are combinational and writes are synchronous. The RAM contents are cleared by reset only when HAS_RST is set.
module ram_NR1W_behav_core #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int RD_PORT_NB = 1,
  parameter bit HAS_RST    = 1'b0,
  localparam int ADD_W     = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  s_rst_n,
  input  logic                                  wr_en,
  input  logic [ADD_W-1:0]                      wr_add,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic [RD_PORT_NB-1:0][ADD_W-1:0]      rd_add,
  output logic [RD_PORT_NB-1:0][WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_unusedRst;

  // In the reset-free build, s_rst_n is deliberately left unused.
  assign w_unusedRst = s_rst_n;

  generate
    if (HAS_RST) begin : g_rst
      always_ff @(posedge clk) begin
        if (!s_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (wr_en) begin
          r_mem[wr_add] <= wr_data;
        end
      end
    end else begin : g_noRst
      always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_add] <= wr_data;
      end
    end

    for (genvar g = 0; g < RD_PORT_NB; g++) begin : g_rd
      assign rd_data[g] = r_mem[rd_add[g]];
    end
  endgenerate

endmodule

// File: rtl/lutram_fifo.sv
// LUTRAM-backed FIFO with wrap-bit pointers, an occupancy count and a registered almost_full flag.
// Define LUTRAM_FIFO_OUT_REG_EN to add a registered output stage; with it, capacity is DEPTH+1.
module lutram_fifo
  import ram_wrapper_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  localparam int ADD_W = $clog2(DEPTH),
  localparam int PTR_W = ADD_W + 1,
`ifdef LUTRAM_FIFO_OUT_REG_EN
  localparam int CAP = DEPTH + 1,
`else
  localparam int CAP = DEPTH,
`endif
  localparam int OCC_W = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OCC_W-1:0] occ,
  output logic             almost_full
);

  logic [PTR_W-1:0]           r_wrPtr;
  logic [PTR_W-1:0]           r_rdPtr;
  logic [OCC_W-1:0]           r_occ;
  logic [OCC_W-1:0]           w_occNext;
  logic                       r_af;
  logic                       r_live;
  logic                       w_ramEmpty;
  logic                       w_ramFull;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_rdAdv;
  logic [0:0][ADD_W-1:0]      w_rdAdd;
  logic [0:0][WIDTH-1:0]      w_rdData;

  assign w_ramEmpty = (r_wrPtr == r_rdPtr);
  assign w_ramFull  = (r_wrPtr[ADD_W-1:0] == r_rdPtr[ADD_W-1:0]) &&
                      (r_wrPtr[ADD_W] != r_rdPtr[ADD_W]);

  // r_live keeps in_rdy low through reset and raises it on the first cycle after release.
  assign in_rdy      = r_live && !w_ramFull;
  assign w_push      = in_vld && in_rdy;
  assign w_pop       = out_vld && out_rdy;
  assign occ         = r_occ;
  assign almost_full = r_af;
  assign w_rdAdd[0]  = r_rdPtr[ADD_W-1:0];

  ram_NR1W_behav_core #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RD_PORT_NB (1),
    .HAS_RST    (1'b0)
  ) u_ram (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .wr_en   (w_push),
    .wr_add  (r_wrPtr[ADD_W-1:0]),
    .wr_data (in_data),
    .rd_add  (w_rdAdd),
    .rd_data (w_rdData)
  );

`ifdef LUTRAM_FIFO_OUT_REG_EN
  out_st_e          r_outSt;
  out_st_e          w_outStNext;
  logic             w_load;
  logic [WIDTH-1:0] r_outData;

  assign out_vld  = (r_outSt == OUT_FULL);
  assign out_data = r_outData;
  assign w_rdAdv  = w_load;

  // The stage refills from the RAM whenever it is empty or being popped, so streaming has no bubbles.
  always_comb begin
    w_outStNext = r_outSt;
    w_load      = 1'b0;
    case (r_outSt)
      OUT_EMPTY: begin
        if (!w_ramEmpty) begin
          w_load      = 1'b1;
          w_outStNext = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (w_pop) begin
          if (!w_ramEmpty) w_load = 1'b1;
          else             w_outStNext = OUT_EMPTY;
        end
      end
      default: w_outStNext = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) r_outSt <= OUT_EMPTY;
    else          r_outSt <= w_outStNext;
  end

  always_ff @(posedge clk) begin
    if (w_load) r_outData <= w_rdData[0];
  end
`else
  assign out_vld  = !w_ramEmpty;
  assign out_data = w_rdData[0];
  assign w_rdAdv  = w_pop;
`endif

  always_comb begin
    w_occNext = r_occ;
    if (w_push && !w_pop)      w_occNext = r_occ + OCC_W'(1);
    else if (w_pop && !w_push) w_occNext = r_occ - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
      r_af    <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push)  r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_rdAdv) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_occ <= w_occNext;
      r_af  <= (int'(w_occNext) >= AF_TH);
    end
  end

endmodule

// File: tb/tb_lutram_fifo.sv
// Self-checking bench for lutram_fifo: a queue-based reference model is checked every cycle, with literal checkpoints.
// Honours LUTRAM_FIFO_OUT_REG_EN so it can check either output-stage build.
module tb_lutram_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AF_TH = DEPTH - 2;
`ifdef LUTRAM_FIFO_OUT_REG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif
  localparam int CAP   = DEPTH + (OREG ? 1 : 0);
  localparam int LAT   = OREG ? 2 : 1;
  localparam int OCC_W = $clog2(CAP + 1);

  logic             clk;
  logic             s_rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;
  logic [OCC_W-1:0] occ;
  logic             almost_full;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  // Reference model: words waiting in the RAM, plus an optional one-word output slot.
  logic [WIDTH-1:0] mRam[$];
  logic             mStV = 1'b0;
  logic [WIDTH-1:0] mStD = '0;
  logic             mLive = 1'b0;
  int               mPushCnt = 0;

  lutram_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AF_TH (AF_TH)
  ) dut (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .in_data     (in_data),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .occ         (occ),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic expVld();
    return OREG ? mStV : (mRam.size() > 0);
  endfunction

  function automatic logic [WIDTH-1:0] expData();
    if (OREG) return mStD;
    if (mRam.size() > 0) return mRam[0];
    return '0;
  endfunction

  function automatic int expOcc();
    return mRam.size() + ((OREG && mStV) ? 1 : 0);
  endfunction

  function automatic logic expRdy();
    return mLive && (mRam.size() < DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] d, input logic rdy);
    in_vld  = vld;
    in_data = d;
    out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  // Model update on each active edge; the inputs were settled 1 time unit after the previous edge.
  always @(posedge clk) begin
    logic push, pop;
    if (!s_rst_n) begin
      mRam.delete();
      mStV  = 1'b0;
      mLive = 1'b0;
    end else begin
      push = in_vld && expRdy();
      pop  = out_rdy && expVld();
      if (OREG) begin
        if ((!mStV || pop) && mRam.size() > 0) begin
          mStD = mRam.pop_front();
          mStV = 1'b1;
        end else if (pop) begin
          mStV = 1'b0;
        end
      end else if (pop) begin
        void'(mRam.pop_front());
      end
      if (push) begin
        mRam.push_back(in_data);
        mPushCnt++;
      end
      mLive = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("in_rdy", in_rdy, expRdy());
      checkOutput("out_vld", out_vld, expVld());
      checkOutput("occ", occ, expOcc());
      checkOutput("almost_full", almost_full, expOcc() >= AF_TH);
      if (expVld()) checkOutput("out_data", out_data, expData());
    end
  end

  task automatic drainAll();
    int n = 0;
    while ((out_vld || expOcc() != 0) && n < 64) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_bound", n < 64, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int target;
    s_rst_n = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    @(posedge clk);
    #1;
    chkEn = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_occ", occ, 0);
    checkOutput("rst_in_rdy", in_rdy, 0);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_af", almost_full, 0);

    // Reset release and first word
    s_rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("release_in_rdy", in_rdy, 1);
    applyStimulus(1'b1, 32'hA5, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      checkOutput("first_vld_early", out_vld, 0);
      applyStimulus(1'b0, '0, 1'b0);
    end
    checkOutput("first_vld", out_vld, 1);
    checkOutput("first_data", out_data, 32'hA5);
    checkOutput("first_occ", occ, 1);
    drainAll();

    // Fill past capacity with the consumer stalled
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + i, 1'b0);
      checkOutput("fill_in_rdy", in_rdy, (i + 1 < CAP) ? 1 : 0);
      checkOutput("fill_af", almost_full, (((i + 1 < CAP) ? i + 1 : CAP) >= AF_TH) ? 1 : 0);
    end
    checkOutput("full_occ", occ, CAP);
    checkOutput("full_head", out_data, 32'h100);

    // Push and pop together while full: only the pop happens
    applyStimulus(1'b1, 32'hDEAD, 1'b1);
    checkOutput("fullpop_occ", occ, CAP - 1);
    checkOutput("fullpop_in_rdy", in_rdy, 1);
    checkOutput("fullpop_head", out_data, 32'h101);
    drainAll();

    // Streaming across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, i, 1'b1);
      if (i >= LAT - 1) begin
        checkOutput("stream_occ", occ, LAT);
        checkOutput("stream_vld", out_vld, 1);
        checkOutput("stream_data", out_data, i - LAT + 1);
      end
    end
    drainAll();

    // Random backpressure
    target = mPushCnt + 1000;
    cyc = 0;
    while (mPushCnt < target && cyc < 20000) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      cyc++;
    end
    checkOutput("random_bound", cyc < 20000, 1);
    drainAll();

    // Reset in the middle of operation
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'hBAD0 + i, 1'b0);
    checkOutput("mid_occ", occ, 7);
    s_rst_n = 1'b0;
    applyStimulus(1'b1, 32'hBEEF, 1'b1);
    checkOutput("midrst_occ", occ, 0);
    checkOutput("midrst_out_vld", out_vld, 0);
    checkOutput("midrst_in_rdy", in_rdy, 0);
    s_rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midrel_in_rdy", in_rdy, 1);
    checkOutput("midrel_out_vld", out_vld, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hC000 + i, 1'b0);
    checkOutput("post_head", out_data, 32'hC000);
    drainAll();

    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
